abro_n_machine: RTL and testbench

- Parametrised successor to the two-input ABRO controller (await A and B, emit O, restart on reset).
- Watches N input channels and emits O once every channel has been seen high, then stays quiet until a soft restart R or the hard Reset.
- Adds N channels, selectable any-order or strict-order completion, pulse or level output, and observable progress (Seen, Count).
- Standalone control block, driven directly by the stimulus/monitor structure of the ABRO bench family.

---
 rtl/abro_n_machine.sv | 156 +++++++++++++++
 tb/tb_abro_n_machine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/abro_n_machine.sv
// N-channel ABRO controller: emits O once every channel has been seen high, then waits for R or Reset.
// Optional partial-progress timeout is enabled by defining ABRO_TIMEOUT_EN.
module abro_n_machine #(
   parameter int N              = 4,
   parameter int ORDERED        = 0,
   parameter int PULSE_O        = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       R,
   input  logic [N-1:0]               In,
   output logic                       O,
   output logic [1:0]                 State,
   output logic [N-1:0]               Seen,
   output logic [$clog2(N+1)-1:0]     Count
);

   localparam int CW = $clog2(N+1);

   typedef enum logic [1:0] {
      S_WAIT  = 2'b00,
      S_EMIT  = 2'b01,
      S_DONE  = 2'b10,
      S_ERROR = 2'b11
   } state_t;

   state_t          r_state;
   logic            r_o;
   logic [N-1:0]    r_seen;
   logic [CW-1:0]   r_count;

   logic [N-1:0]    w_merged;
   logic [N-1:0]    w_exp_mask;
   logic [N-1:0]    w_above_mask;
   logic            w_all;
   logic            w_exp_hit;
   logic            w_ord_err;
   logic            w_ord_last;

   function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // Ordered mode: one-hot of the expected channel and the set of channels beyond it.
   always_comb begin
      w_merged     = r_seen | In;
      w_all        = &w_merged;
      w_exp_mask   = '0;
      w_above_mask = '0;
      for (int i = 0; i < N; i++) begin
         w_exp_mask[i]   = (CW'(i) == r_count);
         w_above_mask[i] = (CW'(i) >  r_count);
      end
      w_exp_hit  = |(In & w_exp_mask);
      w_ord_err  = |(In & w_above_mask);
      w_ord_last = (r_count == CW'(N-1));
   end

`ifdef ABRO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);

   logic [TW-1:0]   r_timer;
   logic            w_gain;
   logic            w_tmo_active;
   logic            w_tmo_fire;

   always_comb begin
      if (ORDERED != 0) begin
         w_gain = w_exp_hit && !w_ord_err;
      end else begin
         w_gain = (w_merged != r_seen);
      end
      w_tmo_active = (r_state == S_WAIT) && (r_count != '0) && (r_count != CW'(N));
      w_tmo_fire   = w_tmo_active && (r_timer == TW'(TIMEOUT_CYCLES-1));
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

   always_ff @(posedge Clock) begin
      if (Reset || R) begin
         r_state <= S_WAIT;
         r_o     <= 1'b0;
         r_seen  <= '0;
         r_count <= '0;
`ifdef ABRO_TIMEOUT_EN
         r_timer <= '0;
`endif
      end else begin
         case (r_state)
            S_WAIT: begin
`ifdef ABRO_TIMEOUT_EN
               // Expiry wins over whatever In carries on the same edge.
               if (w_tmo_fire) begin
                  r_seen  <= '0;
                  r_count <= '0;
                  r_timer <= '0;
               end else begin
                  if (w_gain) begin
                     r_timer <= '0;
                  end else if (w_tmo_active) begin
                     r_timer <= r_timer + TW'(1);
                  end
`endif
                  if (ORDERED == 0) begin
                     r_seen  <= w_merged;
                     r_count <= popcount(w_merged);
                     if (w_all) begin
                        r_state <= S_EMIT;
                        r_o     <= 1'b1;
                     end
                  end else if (w_ord_err) begin
                     r_state <= S_ERROR;
                     r_o     <= 1'b0;
                  end else if (w_exp_hit) begin
                     r_seen  <= r_seen | w_exp_mask;
                     r_count <= r_count + CW'(1);
                     if (w_ord_last) begin
                        r_state <= S_EMIT;
                        r_o     <= 1'b1;
                     end
                  end
`ifdef ABRO_TIMEOUT_EN
               end
`endif
            end
            S_EMIT: begin
               r_state <= S_DONE;
               if (PULSE_O != 0) begin
                  r_o <= 1'b0;
               end
            end
            S_DONE: begin
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_ERROR;
               r_o     <= 1'b0;
            end
         endcase
      end
   end

   assign O     = r_o;
   assign State = r_state;
   assign Seen  = r_seen;
   assign Count = r_count;

endmodule

// File: tb/tb_abro_n_machine.sv
// Directed bench for abro_n_machine: any-order, ordered, level-output and N=1 instances.
module tb_abro_n_machine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       r0, r1, r2, r3;
   logic [3:0] in0, in1, in2;
   logic [0:0] in3;

   logic       o0, o1, o2, o3;
   logic [1:0] st0, st1, st2, st3;
   logic [3:0] seen0, seen1, seen2;
   logic [0:0] seen3;
   logic [2:0] cnt0, cnt1, cnt2;
   logic [0:0] cnt3;

   abro_n_machine #(.N(4), .ORDERED(0), .PULSE_O(1), .TIMEOUT_CYCLES(5)) u_any (
      .Clock(clk), .Reset(rst), .R(r0), .In(in0),
      .O(o0), .State(st0), .Seen(seen0), .Count(cnt0));

   abro_n_machine #(.N(4), .ORDERED(1), .PULSE_O(1), .TIMEOUT_CYCLES(5)) u_ord (
      .Clock(clk), .Reset(rst), .R(r1), .In(in1),
      .O(o1), .State(st1), .Seen(seen1), .Count(cnt1));

   abro_n_machine #(.N(4), .ORDERED(0), .PULSE_O(0), .TIMEOUT_CYCLES(5)) u_lvl (
      .Clock(clk), .Reset(rst), .R(r2), .In(in2),
      .O(o2), .State(st2), .Seen(seen2), .Count(cnt2));

   abro_n_machine #(.N(1), .ORDERED(0), .PULSE_O(1), .TIMEOUT_CYCLES(5)) u_one (
      .Clock(clk), .Reset(rst), .R(r3), .In(in3),
      .O(o3), .State(st3), .Seen(seen3), .Count(cnt3));

   typedef struct {
      string      name;
      int         sel;
      logic       rs;
      logic       rr;
      logic [3:0] vin;
      logic [1:0] st;
      logic [3:0] seen;
      logic [2:0] cnt;
      logic       o;
   } vec_t;

   vec_t tbl[$];
   int   n_run  = 0;
   int   n_fail = 0;

   function automatic logic [9:0] obs(input int sel);
      case (sel)
         0:       return {st0, seen0, cnt0, o0};
         1:       return {st1, seen1, cnt1, o1};
         2:       return {st2, seen2, cnt2, o2};
         default: return {5'b0, st3, seen3, cnt3, o3};
      endcase
   endfunction

   task automatic add(input string name, input int sel, input logic rs, input logic rr,
                      input logic [3:0] vin, input logic [1:0] st, input logic [3:0] seen,
                      input logic [2:0] cnt, input logic o);
      vec_t v;
      v.name = name; v.sel = sel; v.rs = rs; v.rr = rr; v.vin = vin;
      v.st = st; v.seen = seen; v.cnt = cnt; v.o = o;
      tbl.push_back(v);
   endtask

   task automatic step(input int sel, input logic rs, input logic rr, input logic [3:0] vin);
      @(negedge clk);
      rst = rs;
      r0 = 1'b0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      case (sel)
         0:       begin r0 = rr; in0 = vin; end
         1:       begin r1 = rr; in1 = vin; end
         2:       begin r2 = rr; in2 = vin; end
         default: begin r3 = rr; in3 = vin[0]; end
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: st/seen/cnt/o got %b required %b", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      r0 = 1'b0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;

      // reset and idle
      add("rst",        0, 1, 0, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      add("idle1",      0, 0, 0, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      add("idle2",      0, 0, 0, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      add("idle3",      0, 0, 0, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      add("idle_ord",   1, 0, 0, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      add("idle_lvl",   2, 0, 0, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      // any-order, pulse output
      add("any_b2",     0, 0, 0, 4'b0100, 2'b00, 4'b0100, 3'd1, 0);
      add("any_b0",     0, 0, 0, 4'b0001, 2'b00, 4'b0101, 3'd2, 0);
      add("any_b3",     0, 0, 0, 4'b1000, 2'b00, 4'b1101, 3'd3, 0);
      add("any_emit",   0, 0, 0, 4'b0010, 2'b01, 4'b1111, 3'd4, 1);
      add("any_done",   0, 0, 0, 4'b0000, 2'b10, 4'b1111, 3'd4, 0);
      add("any_hold",   0, 0, 0, 4'b1111, 2'b10, 4'b1111, 3'd4, 0);
      add("any_r",      0, 0, 1, 4'b1111, 2'b00, 4'b0000, 3'd0, 0);
      // ordered completion
      add("ord_c0",     1, 0, 0, 4'b0001, 2'b00, 4'b0001, 3'd1, 0);
      add("ord_c1",     1, 0, 0, 4'b0011, 2'b00, 4'b0011, 3'd2, 0);
      add("ord_c2",     1, 0, 0, 4'b0100, 2'b00, 4'b0111, 3'd3, 0);
      add("ord_emit",   1, 0, 0, 4'b1000, 2'b01, 4'b1111, 3'd4, 1);
      add("ord_done",   1, 0, 0, 4'b0000, 2'b10, 4'b1111, 3'd4, 0);
      add("ord_r",      1, 0, 1, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      // ordered errors
      add("ord_e_c0",   1, 0, 0, 4'b0001, 2'b00, 4'b0001, 3'd1, 0);
      add("ord_skip",   1, 0, 0, 4'b0100, 2'b11, 4'b0001, 3'd1, 0);
      add("ord_e_hold", 1, 0, 0, 4'b1111, 2'b11, 4'b0001, 3'd1, 0);
      add("ord_e_r",    1, 0, 1, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      add("ord_e2_c0",  1, 0, 0, 4'b0001, 2'b00, 4'b0001, 3'd1, 0);
      add("ord_exp_hi", 1, 0, 0, 4'b0110, 2'b11, 4'b0001, 3'd1, 0);
      add("ord_e2_r",   1, 0, 1, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      add("ord_all0",   1, 0, 0, 4'b1111, 2'b11, 4'b0000, 3'd0, 0);
      add("ord_e3_r",   1, 0, 1, 4'b0000, 2'b00, 4'b0000, 3'd0, 0);
      // level output
      add("lvl_emit",   2, 0, 0, 4'b1111, 2'b01, 4'b1111, 3'd4, 1);
      add("lvl_done",   2, 0, 0, 4'b0000, 2'b10, 4'b1111, 3'd4, 1);
      add("lvl_hold",   2, 0, 0, 4'b0000, 2'b10, 4'b1111, 3'd4, 1);
      add("lvl_r",      2, 0, 1, 4'b1111, 2'b00, 4'b0000, 3'd0, 0);
      // R mid-collection, Reset with R
      add("mid_0110",   0, 0, 0, 4'b0110, 2'b00, 4'b0110, 3'd2, 0);
      add("mid_r",      0, 0, 1, 4'b1001, 2'b00, 4'b0000, 3'd0, 0);
      add("mid_0011",   0, 0, 0, 4'b0011, 2'b00, 4'b0011, 3'd2, 0);
      add("rst_and_r",  0, 1, 1, 4'b1111, 2'b00, 4'b0000, 3'd0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].sel, tbl[i].rs, tbl[i].rr, tbl[i].vin);
         check(tbl[i].name, obs(tbl[i].sel),
               {tbl[i].st, tbl[i].seen, tbl[i].cnt, tbl[i].o});
      end

      // N=1: single channel completes on the next edge
      step(3, 1, 0, 4'b0000);
      check("one_rst",  obs(3), {5'b0, 2'b00, 1'b0, 1'b0, 1'b0});
      step(3, 0, 0, 4'b0001);
      check("one_emit", obs(3), {5'b0, 2'b01, 1'b1, 1'b1, 1'b1});
      step(3, 0, 0, 4'b0001);
      check("one_done", obs(3), {5'b0, 2'b10, 1'b1, 1'b1, 1'b0});

`ifdef ABRO_TIMEOUT_EN
      step(0, 1, 0, 4'b0000);
      step(0, 0, 0, 4'b0001);
      for (int k = 1; k <= 5; k++) begin
         step(0, 0, 0, 4'b0000);
         if (k < 5) check("tmo_wait", obs(0), {2'b00, 4'b0001, 3'd1, 1'b0});
         else       check("tmo_fire", obs(0), {2'b00, 4'b0000, 3'd0, 1'b0});
      end
      step(0, 1, 0, 4'b0000);
      step(0, 0, 0, 4'b0001);
      step(0, 0, 0, 4'b0000);
      step(0, 0, 0, 4'b0000);
      step(0, 0, 0, 4'b0010);
      step(0, 0, 0, 4'b0000);
      step(0, 0, 0, 4'b0000);
      check("tmo_reload", obs(0), {2'b00, 4'b0011, 3'd2, 1'b0});
`else
      step(0, 1, 0, 4'b0000);
      step(0, 0, 0, 4'b0001);
      for (int k = 0; k < 20; k++) begin
         step(0, 0, 0, 4'b0000);
      end
      check("no_tmo_hold", obs(0), {2'b00, 4'b0001, 3'd1, 1'b0});
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
